ord_issuer: RTL and testbench

ORD_ISSUER -- requirements
Module: ord_issuer

---
 rtl/ord_issuer.sv | 131 +++++++++++++
 tb/tb_ord_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ord_issuer.sv
// ord_issuer: allocates transaction IDs from an 8-entry pool and issues
// registered requests toward the ordering engine's RX side. IDs stay busy
// from acceptance until downstream retires them. Illegal retires set a
// sticky error flag.
module ord_issuer #(
  // Maximum number of IDs that may be outstanding at once (1..8)
  parameter int MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic [15:0] req_payload_i,
  input  logic        req_order_i,
  output logic        req_ready_o,
  output logic        rx_valid_o,
  output logic [2:0]  rx_id_o,
  output logic [15:0] rx_payload_o,
  output logic        rx_order_o,
  input  logic        rx_ready_i,
  input  logic        rx_ret_i,
  input  logic [2:0]  rx_ret_id_i,
  output logic [3:0]  outstanding_o,
  output logic        idle_o,
  output logic        err_o
);

  localparam logic [3:0] MaxOutW = 4'(MAX_OUT);

  logic [7:0]  r_busy;
  logic [3:0]  r_count;
  logic        r_rxValid;
  logic [2:0]  r_rxId;
  logic [15:0] r_rxPayload;
  logic        r_rxOrder;
  logic        r_err;

  logic        w_anyFree;
  logic        w_capOk;
  logic        w_pipeFree;
  logic        w_ready;
  logic        w_accept;
  logic [2:0]  w_freeId;
  logic        w_retHit;
  logic        w_retOk;
  logic        w_retBad;
  logic [7:0]  w_setMask;
  logic [7:0]  w_clrMask;
  logic [7:0]  w_busyNext;
  logic [3:0]  w_countNext;

  // Acceptance depends only on registered state plus the downstream ready,
  // and is forced low while reset is held so nothing slips in during reset.
  assign w_anyFree  = ~(&r_busy);
  assign w_capOk    = r_count < MaxOutW;
  assign w_pipeFree = ~r_rxValid | rx_ready_i;
  assign w_ready    = w_anyFree & w_capOk & w_pipeFree & ~reset;
  assign w_accept   = req_valid_i & w_ready;

  // A retire is only honoured for a busy ID that is not the one still
  // waiting in the output register; anything else is a protocol error.
  assign w_retHit = r_rxValid & (r_rxId == rx_ret_id_i);
  assign w_retOk  = rx_ret_i & r_busy[rx_ret_id_i] & ~w_retHit;
  assign w_retBad = rx_ret_i & ~w_retOk;

  assign w_setMask  = w_accept ? (8'b1 << w_freeId) : 8'b0;
  assign w_clrMask  = w_retOk ? (8'b1 << rx_ret_id_i) : 8'b0;
  assign w_busyNext = (r_busy & ~w_clrMask) | w_setMask;

  // Lowest-index free ID, taken from the registered bitmap so an ID freed
  // this cycle only becomes allocatable on the next one.
  always_comb begin
    w_freeId = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_freeId = 3'(i);
      end
    end
  end

  // Population count of the next bitmap, so the outstanding count is a
  // plain register that always matches the busy bits.
  always_comb begin
    w_countNext = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_countNext = w_countNext + {3'b000, w_busyNext[i]};
    end
  end

  // Busy bitmap, outstanding count and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 8'd0;
      r_count <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busyNext;
      r_count <= w_countNext;
      if (w_retBad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output stage: load on acceptance, drop after a handshake with nothing
  // new behind it, otherwise hold everything stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxValid   <= 1'b0;
      r_rxId      <= 3'd0;
      r_rxPayload <= 16'd0;
      r_rxOrder   <= 1'b0;
    end else if (w_accept) begin
      r_rxValid   <= 1'b1;
      r_rxId      <= w_freeId;
      r_rxPayload <= req_payload_i;
      r_rxOrder   <= req_order_i;
    end else if (r_rxValid && rx_ready_i) begin
      r_rxValid   <= 1'b0;
    end
  end

  assign req_ready_o   = w_ready;
  assign rx_valid_o    = r_rxValid;
  assign rx_id_o       = r_rxId;
  assign rx_payload_o  = r_rxPayload;
  assign rx_order_o    = r_rxOrder;
  assign outstanding_o = r_count;
  assign idle_o        = (r_count == 4'd0) & ~r_rxValid;
  assign err_o         = r_err;

endmodule

// File: tb/tb_ord_issuer.sv
// Testbench for ord_issuer: directed vector table, hand-written corner
// sequences, a MAX_OUT=2 instance, and randomized traffic checked against
// a pool-level reference model.
module tb_ord_issuer;

  typedef struct {
    logic        rv;
    logic [15:0] pl;
    logic        ord;
    logic        rr;
    logic        ret;
    logic [2:0]  rid;
    logic        expReady;
    logic        expValid;
    logic [2:0]  expId;
    logic [3:0]  expOut;
    logic        expErr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        reqValid, reqOrder, reqReady, rxValid, rxOrder;
  logic        rxReady, rxRet, idle, err;
  logic [15:0] reqPayload, rxPayload;
  logic [2:0]  rxId, rxRetId;
  logic [3:0]  outstanding;

  logic        reqValid2, reqOrder2, reqReady2, rxValid2, rxOrder2;
  logic        rxReady2, rxRet2, idle2, err2;
  logic [15:0] reqPayload2, rxPayload2;
  logic [2:0]  rxId2, rxRetId2;
  logic [3:0]  outstanding2;

  int checks = 0;
  int failures = 0;

  vec_t vecs[18];
  vec_t vecs2[6];

  bit        mBusy[8];
  bit        mValid;
  bit [2:0]  mId;
  bit [15:0] mPayload;
  bit        mOrder;
  bit        mErr;

  // Free-running clock
  always #5 clk = ~clk;

  ord_issuer #(.MAX_OUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(reqValid), .req_payload_i(reqPayload), .req_order_i(reqOrder),
    .req_ready_o(reqReady),
    .rx_valid_o(rxValid), .rx_id_o(rxId), .rx_payload_o(rxPayload), .rx_order_o(rxOrder),
    .rx_ready_i(rxReady), .rx_ret_i(rxRet), .rx_ret_id_i(rxRetId),
    .outstanding_o(outstanding), .idle_o(idle), .err_o(err)
  );

  ord_issuer #(.MAX_OUT(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid_i(reqValid2), .req_payload_i(reqPayload2), .req_order_i(reqOrder2),
    .req_ready_o(reqReady2),
    .rx_valid_o(rxValid2), .rx_id_o(rxId2), .rx_payload_o(rxPayload2), .rx_order_o(rxOrder2),
    .rx_ready_i(rxReady2), .rx_ret_i(rxRet2), .rx_ret_id_i(rxRetId2),
    .outstanding_o(outstanding2), .idle_o(idle2), .err_o(err2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] p, input logic o,
                               input logic rr, input logic r, input logic [2:0] rid);
    reqValid   = v;
    reqPayload = p;
    reqOrder   = o;
    rxReady    = rr;
    rxRet      = r;
    rxRetId    = rid;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int mCount();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mBusy[i]);
    return c;
  endfunction

  function automatic int mLowestFree();
    for (int i = 0; i < 8; i++) if (!mBusy[i]) return i;
    return 8;
  endfunction

  function automatic bit mReady(input logic rr);
    return (mCount() < 8) && (mCount() < 8) && (!mValid || rr);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mBusy[i] = 1'b0;
    mValid = 1'b0; mId = 3'd0; mPayload = 16'd0; mOrder = 1'b0; mErr = 1'b0;
  endtask

  // One clock edge of the pool model, using inputs as driven this cycle
  task automatic modelEdge();
    int  freeId;
    bit  acc;
    bit  ok;
    freeId = mLowestFree();
    acc    = reqValid && mReady(rxReady);
    ok     = rxRet && mBusy[rxRetId] && !(mValid && mId == rxRetId);
    if (rxRet && !ok) mErr = 1'b1;
    if (ok) mBusy[rxRetId] = 1'b0;
    if (acc) begin
      mBusy[freeId] = 1'b1;
      mValid   = 1'b1;
      mId      = 3'(freeId);
      mPayload = reqPayload;
      mOrder   = reqOrder;
    end else if (mValid && rxReady) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    // Directed vector table: fill pool, retire/reallocate, error cases
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 16'h1000 + 16'(i), 1'(i), 1'b1, 1'b0, 3'd0,
                  1'b1, 1'b1, 3'(i), 4'(i + 1), 1'b0};
    vecs[8]  = '{1'b1, 16'h2000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 4'd8, 1'b0};
    vecs[9]  = '{1'b1, 16'h2001, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd7, 4'd7, 1'b0};
    vecs[10] = '{1'b1, 16'h2002, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 4'd8, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd5, 4'd7, 1'b0};
    vecs[12] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 4'd7, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 3'd2, 4'd7, 1'b1};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 4'd7, 1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 4'd6, 1'b1};
    vecs[16] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 4'd7, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 4'd7, 1'b1};

    // MAX_OUT=2 instance: third request stalls until ID 0 is retired
    vecs2[0] = '{1'b1, 16'h0A00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
    vecs2[1] = '{1'b1, 16'h0A01, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 4'd2, 1'b0};
    vecs2[2] = '{1'b1, 16'h0A02, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 4'd2, 1'b0};
    vecs2[3] = '{1'b1, 16'h0A02, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 4'd2, 1'b0};
    vecs2[4] = '{1'b1, 16'h0A02, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 4'd1, 1'b0};
    vecs2[5] = '{1'b1, 16'h0A02, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 4'd2, 1'b0};

    reqValid2 = 1'b0; reqPayload2 = 16'd0; reqOrder2 = 1'b0;
    rxReady2 = 1'b0; rxRet2 = 1'b0; rxRetId2 = 3'd0;

    // Reset state, with a request pending to show ready stays low
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 3'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_outputs", {rxValid, rxId, rxPayload, rxOrder, outstanding, err, idle},
                {1'b1 ^ 1'b1, 3'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1});
    checkOutput("rst_ready", reqReady, 1'b0);
    checkOutput("rst_ready2", reqReady2, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].pl, vecs[i].ord, vecs[i].rr, vecs[i].ret, vecs[i].rid);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), reqReady, vecs[i].expReady);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_post", i), {rxValid, rxId, outstanding, err},
                  {vecs[i].expValid, vecs[i].expId, vecs[i].expOut, vecs[i].expErr});
    end

    for (int i = 0; i < 6; i++) begin
      reqValid2 = vecs2[i].rv; reqPayload2 = vecs2[i].pl; reqOrder2 = vecs2[i].ord;
      rxReady2 = vecs2[i].rr; rxRet2 = vecs2[i].ret; rxRetId2 = vecs2[i].rid;
      #1;
      checkOutput($sformatf("max2_%0d_ready", i), reqReady2, vecs2[i].expReady);
      @(negedge clk);
      checkOutput($sformatf("max2_%0d_post", i), {rxValid2, rxId2, outstanding2},
                  {vecs2[i].expValid, vecs2[i].expId, vecs2[i].expOut});
    end
    reqValid2 = 1'b0; rxRet2 = 1'b0;

    // Backpressure: held transaction stays stable, no new acceptance
    doReset();
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 3'd0);
    #1 checkOutput("stall_first_ready", reqReady, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("stall%0d_ready", i), reqReady, 1'b0);
      checkOutput($sformatf("stall%0d_hold", i), {rxValid, rxId, rxPayload, rxOrder, outstanding},
                  {1'b1, 3'd0, 16'hBEEF, 1'b1, 4'd1});
      @(negedge clk);
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    #1 checkOutput("stall_release_ready", reqReady, 1'b1);
    @(negedge clk);
    checkOutput("stall_release_post", {rxValid, outstanding, idle}, {1'b0, 4'd1, 1'b0});

    // Reset in the middle of a held transaction with three IDs busy
    doReset();
    applyStimulus(1'b1, 16'h0C00, 1'b0, 1'b1, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("midrst_before", {rxValid, rxId, outstanding, idle}, {1'b1, 3'd2, 4'd3, 1'b0});
    applyStimulus(1'b1, 16'h0D00, 1'b0, 1'b1, 1'b0, 3'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_outputs", {rxValid, rxId, rxPayload, rxOrder, outstanding, err, idle},
                {1'b0, 3'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1});
    checkOutput("midrst_ready", reqReady, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("midrst_after_ready", reqReady, 1'b1);
    @(negedge clk);
    checkOutput("midrst_first_id", {rxValid, rxId, rxPayload, outstanding},
                {1'b1, 3'd0, 16'h0D00, 4'd1});

    // Randomized traffic against the pool model
    doReset();
    modelReset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] rid;
      bit         legal;
      bit         doRet;
      rid   = 3'($urandom_range(0, 7));
      legal = mBusy[rid] && !(mValid && mId == rid);
      doRet = (legal && $urandom_range(0, 1) == 1) || (n >= 340 && $urandom_range(0, 15) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, doRet, rid);
      #1;
      checkOutput($sformatf("rnd%0d_ready", n), reqReady, mReady(rxReady));
      checkOutput($sformatf("rnd%0d_state", n),
                  {rxValid, rxId, rxPayload, rxOrder, outstanding, idle, err},
                  {mValid, mId, mPayload, mOrder, 4'(mCount()),
                   (mCount() == 0) && !mValid, mErr});
      @(posedge clk);
      modelEdge();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
